// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard stall/flush controller.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] X0 = '0;
    localparam int MULDIV_LAT_DEF = 4;

endpackage

// File: rtl/hazard_muldiv_ctr.sv
// Tracks a multi-cycle mul/div occupying execute and raises the stall
// for every cycle except its last.
module hazard_muldiv_ctr
    import hazard_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEF,
    parameter int CNT_W      = $clog2(MULDIV_LAT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic MulDivStartCH,
    output logic mdstall,
    output logic busy
);

    localparam logic              LAT_GT1  = (MULDIV_LAT > 1);
    localparam logic [CNT_W-1:0]  LOAD_VAL = CNT_W'(MULDIV_LAT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             idle;

    assign idle = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (!idle) begin
            cnt_d = cnt_q - CNT_ONE;
        end else if (MulDivStartCH && LAT_GT1) begin
            cnt_d = LOAD_VAL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The last occupancy cycle (cnt==1) does not stall: the op leaves C on that edge.
    assign mdstall = (MulDivStartCH && idle && LAT_GT1) || (cnt_q > CNT_ONE);
    assign busy    = !idle;

endmodule

// File: rtl/hazard_stall.sv
// Stall/flush controller for load-use, taken branch and mul/div occupancy.
// Mul/div tracking is compiled in only when HAZARD_MULDIV_EN is defined.
module hazard_stall
    import hazard_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEF,
    parameter int CNT_W      = $clog2(MULDIV_LAT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] Rs1BH,
    input  logic [REG_ADDR_W-1:0] Rs2BH,
    input  logic [REG_ADDR_W-1:0] RdCH,
    input  logic                  MemReadCH,
    input  logic                  PCSrcCH,
    input  logic                  MulDivStartCH,
    output logic                  StallAH,
    output logic                  StallBH,
    output logic                  StallCH,
    output logic                  FlushBH,
    output logic                  FlushCH,
    output logic                  FlushDH,
    output logic                  MulDivBusyH
);

    logic loaduse;
    logic mdstall;
    logic md_busy;

    assign loaduse = MemReadCH && (RdCH != X0) && ((RdCH == Rs1BH) || (RdCH == Rs2BH));

`ifdef HAZARD_MULDIV_EN
    hazard_muldiv_ctr #(
        .MULDIV_LAT (MULDIV_LAT),
        .CNT_W      (CNT_W)
    ) u_muldiv_ctr (
        .clk           (clk),
        .rst_n         (rst_n),
        .MulDivStartCH (MulDivStartCH),
        .mdstall       (mdstall),
        .busy          (md_busy)
    );
`else
    logic unused_md;
    assign unused_md = &{1'b0, clk, MulDivStartCH};
    assign mdstall   = 1'b0;
    assign md_busy   = 1'b0;
`endif

    // A mul/div in C outranks the branch: the branch is re-evaluated once the op completes.
    always_comb begin
        StallAH = 1'b0;
        StallBH = 1'b0;
        StallCH = 1'b0;
        FlushBH = 1'b0;
        FlushCH = 1'b0;
        FlushDH = 1'b0;
        if (!rst_n) begin
            StallAH = 1'b0;
        end else if (mdstall) begin
            StallAH = 1'b1;
            StallBH = 1'b1;
            StallCH = 1'b1;
            FlushDH = 1'b1;
        end else if (PCSrcCH) begin
            FlushBH = 1'b1;
            FlushCH = 1'b1;
        end else if (loaduse) begin
            StallAH = 1'b1;
            StallBH = 1'b1;
            FlushCH = 1'b1;
        end
    end

    assign MulDivBusyH = md_busy && rst_n;

endmodule

// File: tb/tb_hazard_stall.sv
// Self-checking bench for hazard_stall: directed scenarios then random
// stimulus against an occupancy-based reference model.
module tb_hazard_stall;

    localparam int LAT = 4;

`ifdef HAZARD_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] Rs1BH = '0, Rs2BH = '0, RdCH = '0;
    logic       MemReadCH = 1'b0, PCSrcCH = 1'b0, MulDivStartCH = 1'b0;
    logic       StallAH, StallBH, StallCH, FlushBH, FlushCH, FlushDH, MulDivBusyH;

    int checks = 0;
    int errors = 0;
    // Cycles the current mul/div still occupies C, as seen before this cycle.
    int occ_left = 0;

    always #5 clk = ~clk;

    hazard_stall #(.MULDIV_LAT(LAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Rs1BH         (Rs1BH),
        .Rs2BH         (Rs2BH),
        .RdCH          (RdCH),
        .MemReadCH     (MemReadCH),
        .PCSrcCH       (PCSrcCH),
        .MulDivStartCH (MulDivStartCH),
        .StallAH       (StallAH),
        .StallBH       (StallBH),
        .StallCH       (StallCH),
        .FlushBH       (FlushBH),
        .FlushCH       (FlushCH),
        .FlushDH       (FlushDH),
        .MulDivBusyH   (MulDivBusyH)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Compute expectations from current inputs and model, compare all outputs.
    task automatic check_outputs(input string tag);
        int  cur_left;
        bit  md, lu, e_sa, e_sb, e_sc, e_fb, e_fc, e_fd, e_busy;
        cur_left = occ_left;
        if (MD_EN && occ_left == 0 && MulDivStartCH) cur_left = LAT;
        md = MD_EN && (cur_left > 1);
        lu = MemReadCH && (RdCH != 0) && (RdCH == Rs1BH || RdCH == Rs2BH);
        e_busy = MD_EN && (occ_left > 0);
        {e_sa, e_sb, e_sc, e_fb, e_fc, e_fd} = '0;
        if (!rst_n) begin
            e_busy = 1'b0;
        end else if (md) begin
            {e_sa, e_sb, e_sc, e_fd} = 4'b1111;
        end else if (PCSrcCH) begin
            {e_fb, e_fc} = 2'b11;
        end else if (lu) begin
            {e_sa, e_sb, e_fc} = 3'b111;
        end
        chk({tag, ".StallAH"}, StallAH, e_sa);
        chk({tag, ".StallBH"}, StallBH, e_sb);
        chk({tag, ".StallCH"}, StallCH, e_sc);
        chk({tag, ".FlushBH"}, FlushBH, e_fb);
        chk({tag, ".FlushCH"}, FlushCH, e_fc);
        chk({tag, ".FlushDH"}, FlushDH, e_fd);
        chk({tag, ".MulDivBusyH"}, MulDivBusyH, e_busy);
    endtask

    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic mr, input logic pc, input logic md, input string tag);
        int cur_left;
        @(negedge clk);
        Rs1BH = rs1; Rs2BH = rs2; RdCH = rd;
        MemReadCH = mr; PCSrcCH = pc; MulDivStartCH = md;
        #1;
        check_outputs(tag);
        cur_left = occ_left;
        if (MD_EN && occ_left == 0 && MulDivStartCH) cur_left = LAT;
        @(posedge clk);
        if (rst_n) occ_left = (cur_left > 0) ? cur_left - 1 : 0;
        else occ_left = 0;
    endtask

    initial begin
        // Reset, with a load-use pattern present to show gating.
        Rs1BH = 5'd5; RdCH = 5'd5; MemReadCH = 1'b1; MulDivStartCH = 1'b1; PCSrcCH = 1'b1;
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step(5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, "lu_rs1");
        step(5'd5, 5'd1, 5'd9, 1'b0, 1'b0, 1'b0, "lu_after");
        step(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, "lu_x0");
        step(5'd3, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, "lu_branch");
        step(5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, "lu_rs2");
        step(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, "idle");

        // Held start: two back-to-back ops.
        for (int i = 0; i < 2 * LAT; i++) step(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, "md_held");
        step(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, "md_done");

        // Async reset mid-op (counter at 2).
        step(5'd4, 5'd2, 5'd4, 1'b1, 1'b0, 1'b1, "md_r0");
        step(5'd4, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, "md_r1");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        occ_left = 0;
        #1;
        check_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 1; i++) step(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, (i == 0), "md_restart");

        // Random phase: small address space for frequent hits.
        for (int i = 0; i < 300; i++) begin
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 4) == 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall.md
# hazard_stall

Stall/flush controller for the five-stage pipeline; the counterpart to the forwarding unit. Forwarding resolves data hazards by steering results back into execute (C). This block handles the hazards forwarding cannot resolve and drives the pipeline register enables and clears:
- load-use dependencies,
- taken-branch redirects,
- multi-cycle mul/div occupancy of C.

Stages are A fetch, B decode, C execute, D memory, E writeback.

## Interface
Parameters:
- MULDIV_LAT, 4, total cycles a mul/div op occupies C (legal ≥1).
- CNT_W, $clog2(MULDIV_LAT+1), counter width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- Rs1BH  in  5  rs1 address of the instruction in B.
- Rs2BH  in  5  rs2 address of the instruction in B.
- RdCH  in  5  destination address of the instruction in C.
- MemReadCH  in  1  the instruction in C is a load.
- PCSrcCH  in  1  branch/jump taken, resolved in C.
- MulDivStartCH  in  1  the instruction in C is mul/div.
- StallAH  out  1  hold PC.
- StallBH  out  1  hold the A/B pipeline register.
- StallCH  out  1  hold the B/C pipeline register.
- FlushBH  out  1  clear the A/B pipeline register.
- FlushCH  out  1  clear the B/C pipeline register (bubble).
- FlushDH  out  1  clear the C/D pipeline register (bubble).
- MulDivBusyH  out  1  mul/div in progress (debug/perf).

## Operation
- The only state is the mul/div counter `cnt` (CNT_W bits).
- Outputs are combinational from the inputs and `cnt`.

Definitions:
- loaduse = MemReadCH & (RdCH≠0) & ((RdCH==Rs1BH) | (RdCH==Rs2BH)).
- mdstall = (MulDivStartCH & cnt==0 & MULDIV_LAT>1) | (cnt>1).

Counter behaviour:
- IDLE (cnt==0), MulDivStartCH=1, MULDIV_LAT>1: cnt ← MULDIV_LAT−1.
- cnt>0: cnt ← cnt−1.
- cnt==1: stall drops and the op leaves C on that edge.
- A mul/div arriving in C the cycle after another completes starts fresh, because cnt is 0 again.

Output priority, highest first:
1. rst_n=0: all outputs 0.
2. mdstall: StallAH=StallBH=StallCH=1, FlushDH=1. PCSrcCH and loaduse are ignored, since C holds a mul/div.
3. PCSrcCH: FlushBH=FlushCH=1, no stalls. This kills any load-use stall from a wrong-path instruction.
4. loaduse: StallAH=StallBH=1, FlushCH=1.
5. Otherwise all outputs 0.

MulDivBusyH = (cnt≠0).

## Timing
- Reset: cnt=0; every output is 0 while rst_n=0.
- Asserting rst_n low mid-operation clears cnt asynchronously and drops the stall immediately.
- Load-use: exactly one stall cycle. The next cycle the load is in D, forwarding supplies the data, and loaduse deasserts.
- Branch: 1-cycle flush of B and C. The PC redirect happens on the same edge.
- Mul/div: exactly MULDIV_LAT−1 stall cycles, counted from the first cycle the op is in C.
- MULDIV_LAT=1: no stall, and cnt never leaves 0.
- No combinational path from any output to any input.

## Configuration
- HAZARD_MULDIV_EN defined: the counter, mdstall and MulDivBusyH are compiled in as above.
- HAZARD_MULDIV_EN undefined:
  - no counter registers;
  - MulDivStartCH is unused;
  - mdstall is tied to 0;
  - StallCH, FlushDH and MulDivBusyH are tied to 0;
  - the block is purely combinational.

## Structure
- Shared package hazard_pkg:
  - REG_ADDR_W=5;
  - X0 address constant;
  - default MULDIV_LAT.
- One sub-module, hazard_muldiv_ctr:
  - contains the counter and mdstall logic;
  - inputs clk, rst_n, MulDivStartCH; outputs mdstall and busy;
  - instantiated only under HAZARD_MULDIV_EN.

## Test plan
- Load x5 in C, Rs1BH=5 → StallAH=StallBH=FlushCH=1 for one cycle, then all 0. Repeat with RdCH=0 → no stall.
- Load x7 in C, Rs2BH=7, with PCSrcCH=1 the same cycle → FlushBH=FlushCH=1 and StallAH=0.
- MULDIV_LAT=4, MulDivStartCH held high → stalls plus FlushDH=1 for exactly 3 cycles. cnt sequence 0→3→2→1→0.
- Back-to-back mul/div → two 3-cycle stall windows separated by one non-stall cycle.
- rst_n pulsed low while cnt=2 → all outputs drop asynchronously; after release cnt=0 and MulDivStartCH restarts a full 3-cycle stall.
- Build without HAZARD_MULDIV_EN, MulDivStartCH=1 → StallCH=FlushDH=MulDivBusyH=0; load-use and branch behaviour unchanged.
